// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: two producer valid/ready channels, the register
// file write port, and the optional forwarding lookups (WB_BYPASS_EN).
interface wb_arbiter_if;
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // ready depends only on FIFO occupancy (never on valid); producers hold
  // valid/rd/data stable until the transfer.
  logic        i_alu_valid;
  logic        o_alu_ready;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic [4:0]  o_reg_waddr;
  logic [31:0] o_reg_wdata;
  logic        o_reg_wena;
  logic        o_busy;
`ifdef WB_BYPASS_EN
  logic [4:0]  i_fwd1_raddr;
  logic [4:0]  i_fwd2_raddr;
  logic        o_fwd1_hit;
  logic        o_fwd2_hit;
  logic [31:0] o_fwd1_data;
  logic [31:0] o_fwd2_data;
`endif

  modport master (
`ifdef WB_BYPASS_EN
    output i_fwd1_raddr, i_fwd2_raddr,
    input  o_fwd1_hit, o_fwd2_hit, o_fwd1_data, o_fwd2_data,
`endif
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  o_alu_ready, o_lsu_ready,
    input  o_reg_waddr, o_reg_wdata, o_reg_wena, o_busy
  );

  modport slave (
`ifdef WB_BYPASS_EN
    input  i_fwd1_raddr, i_fwd2_raddr,
    output o_fwd1_hit, o_fwd2_hit, o_fwd1_data, o_fwd2_data,
`endif
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    output o_alu_ready, o_lsu_ready,
    output o_reg_waddr, o_reg_wdata, o_reg_wena, o_busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-producer FIFOs (ALU, LSU), LSU-priority arbitration
// with ALU starvation guard, registered regfile write. WB_BYPASS_EN adds forwarding.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  wb_arbiter_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef logic [36:0] entry_t;  // {rd, data}

  // Index 0 is the ALU channel, index 1 is the LSU channel.
  entry_t        mem [2][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic          full   [2];
  logic          empty  [2];
  logic          push   [2];
  logic          pop    [2];
  logic          in_valid [2];
  entry_t        in_entry [2];
  entry_t        head   [2];

  logic [SW-1:0] starve_cnt;
  logic          alu_win;
  logic [4:0]    reg_waddr;
  logic [31:0]   reg_wdata;
  logic          reg_wena;

  assign in_valid[0] = bus.i_alu_valid;
  assign in_valid[1] = bus.i_lsu_valid;
  assign in_entry[0] = {bus.i_alu_rd, bus.i_alu_data};
  assign in_entry[1] = {bus.i_lsu_rd, bus.i_lsu_data};

  // Wrap bit distinguishes full from empty when the index bits match.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      // rd==0 still handshakes but is never stored.
      push[i]  = in_valid[i] && !full[i] && (in_entry[i][36:32] != 5'd0);
      head[i]  = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  assign alu_win = !empty[0] && (empty[1] || (starve_cnt == STARVE_LIM));
  assign pop[0]  = alu_win;
  assign pop[1]  = !empty[1] && !alu_win;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_entry[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      starve_cnt <= '0;
      reg_wena   <= 1'b0;
      reg_waddr  <= '0;
      reg_wdata  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
      end
      // ALU non-empty and not granted means it lost to the LSU this cycle.
      if (empty[0] || pop[0])
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + SW'(1);
      reg_wena <= pop[0] || pop[1];
      if (pop[0]) begin
        reg_waddr <= head[0][36:32];
        reg_wdata <= head[0][31:0];
      end else if (pop[1]) begin
        reg_waddr <= head[1][36:32];
        reg_wdata <= head[1][31:0];
      end
    end
  end

  assign bus.o_alu_ready = !full[0];
  assign bus.o_lsu_ready = !full[1];
  assign bus.o_reg_waddr = reg_waddr;
  assign bus.o_reg_wdata = reg_wdata;
  assign bus.o_reg_wena  = reg_wena;
  assign bus.o_busy      = !empty[0] || !empty[1] || reg_wena;

`ifdef WB_BYPASS_EN
  logic fwd1_hit;
  logic fwd2_hit;
  // Covers the same-cycle write-then-read hazard of the regfile read port.
  assign fwd1_hit = reg_wena && (bus.i_fwd1_raddr == reg_waddr) && (bus.i_fwd1_raddr != 5'd0);
  assign fwd2_hit = reg_wena && (bus.i_fwd2_raddr == reg_waddr) && (bus.i_fwd2_raddr != 5'd0);
  assign bus.o_fwd1_hit  = fwd1_hit;
  assign bus.o_fwd2_hit  = fwd2_hit;
  assign bus.o_fwd1_data = fwd1_hit ? reg_wdata : 32'd0;
  assign bus.o_fwd2_data = fwd2_hit ? reg_wdata : 32'd0;
`endif

endmodule
